fetch_unit: RTL

Instruction fetch stage that owns the architectural PC register and sits directly downstream of the PC control block. It issues 16-bit instruction fetches to instruction memory over a req/rdy handshake, and presents the fetched instruction, its PC and PC+2 to decode. It also accepts the branch-resolved next PC as a redirect, honours stalls from the hazard unit, and stops fetching on HLT.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_skid_buf.sv | 53 +++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage: word width, opcode type,
// fetch FSM states and the PC increment.
package cpu_pkg;

    localparam int unsigned WORD_W = 16;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OPC_HLT = 4'hF;

    localparam logic [WORD_W-1:0] PC_INC = 16'h0002;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC holding register used by fetch_unit when built
// with FETCH_SKID_EN. Clear beats load, load beats pop.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              pop,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [WORD_W-1:0] pc_in,
    output logic              valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches 16-bit words over req/rdy,
// handles redirect, stall and HLT. Optional skid buffer: FETCH_SKID_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter opcode_t           HLT_OPC  = OPC_HLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] pc_next,
    input  logic              redirect,
    input  logic              stall,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [WORD_W-1:0] imem_data,
    output logic [WORD_W-1:0] instr_out,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] pc_plus2_out,
    output logic              valid_out,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pc_out_q, pc_out_d;
    logic [WORD_W-1:0] pc_p2_q, pc_p2_d;
    logic              valid_q, valid_d;
    logic              xfer;
    logic              is_hlt;

`ifdef FETCH_SKID_EN
    logic              skid_load, skid_clear, skid_pop, skid_valid;
    logic [WORD_W-1:0] skid_instr, skid_pc;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .clear    (skid_clear),
        .pop      (skid_pop),
        .instr_in (imem_data),
        .pc_in    (pc_q),
        .valid    (skid_valid),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );
`endif

    // Request is gated by rst so nothing is requested while reset is held.
    always_comb begin
`ifdef FETCH_SKID_EN
        imem_req = ~rst & ((state_q == FETCH) |
                           ((state_q == HOLD) & stall & ~skid_valid));
`else
        imem_req = ~rst & (state_q == FETCH);
`endif
    end

    assign xfer      = imem_req & imem_rdy;
    assign is_hlt    = (opcode_t'(imem_data[15:12]) == HLT_OPC);
    assign imem_addr = pc_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        pc_p2_d  = pc_p2_q;
        valid_d  = valid_q;
`ifdef FETCH_SKID_EN
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        skid_pop   = 1'b0;
`endif
        if (redirect) begin
            pc_d    = pc_next;
            valid_d = 1'b0;
            state_d = FETCH;
`ifdef FETCH_SKID_EN
            skid_clear = 1'b1;
`endif
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (stall && valid_q) begin
                        state_d = HOLD;
                    end else if (xfer) begin
                        instr_d  = imem_data;
                        pc_out_d = pc_q;
                        pc_p2_d  = pc_q + PC_INC;
                        valid_d  = 1'b1;
                        if (is_hlt) state_d = HALT;
                        else        pc_d    = pc_q + PC_INC;
                    end else if (!stall) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
`ifdef FETCH_SKID_EN
                    // A word caught while stalled is presented straight on release.
                    if (xfer) begin
                        skid_load = 1'b1;
                        if (!is_hlt) pc_d = pc_q + PC_INC;
                    end
                    if (!stall) begin
                        state_d = FETCH;
                        if (skid_valid) begin
                            skid_pop = 1'b1;
                            instr_d  = skid_instr;
                            pc_out_d = skid_pc;
                            pc_p2_d  = skid_pc + PC_INC;
                            valid_d  = 1'b1;
                            if (opcode_t'(skid_instr[15:12]) == HLT_OPC) state_d = HALT;
                        end
                    end
`else
                    if (!stall) state_d = FETCH;
`endif
                end
                HALT: begin
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= RESET_PC;
            pc_p2_q  <= RESET_PC + PC_INC;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            pc_p2_q  <= pc_p2_d;
            valid_q  <= valid_d;
        end
    end

    assign instr_out    = instr_q;
    assign pc_out       = pc_out_q;
    assign pc_plus2_out = pc_p2_q;
    assign valid_out    = valid_q;
    assign halted       = (state_q == HALT);

endmodule
